// File: rtl/bram_bank_arbiter.sv
// Multi-requester, multi-bank BRAM arbiter: per-bank fixed-priority or round-robin
// grant, registered bank issue, per-bank read tag pipelines, saturating stall counter.
module bram_bank_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int RR_MODE   = 1,
    localparam int BS_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
    localparam int BA_W     = ADDR_W - BS_W,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0]     rsp_rdata,
    output logic [NUM_BANKS-1:0]          bank_en,
    output logic [NUM_BANKS-1:0]          bank_we,
    output logic [NUM_BANKS*BA_W-1:0]     bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata,
    output logic [15:0]                   stall_cnt,
    input  logic                          stall_clr
);

    function automatic int unsigned bank_of(input logic [ADDR_W-1:0] a);
        return 32'(a >> BA_W);
    endfunction

    logic [NUM_REQ-1:0]              elig    [NUM_BANKS];
    logic [NUM_REQ-1:0]              onehot  [NUM_BANKS];
    logic [NUM_BANKS-1:0]            win_vld;
    logic [ID_W-1:0]                 win_id  [NUM_BANKS];
    logic [NUM_BANKS-1:0]            win_we;
    logic [BA_W-1:0]                 win_addr  [NUM_BANKS];
    logic [DATA_W-1:0]               win_wdata [NUM_BANKS];
    logic [NUM_REQ-1:0]              grant;
    logic [ID_W-1:0]                 rr_ptr  [NUM_BANKS];
    logic [ID_W-1:0]                 issue_id [NUM_BANKS];
    logic [RD_LAT-1:0]               tag_vld [NUM_BANKS];
    logic [RD_LAT-1:0][ID_W-1:0]     tag_id  [NUM_BANKS];
    logic [NUM_REQ-1:0]              rsp_vld_nxt;
    logic [NUM_REQ*DATA_W-1:0]       rsp_data_nxt;
    logic                            stall_any;

    // A requester whose req_ready is high this cycle is masked so one request
    // is never granted twice.
    always_comb begin : arb
        logic [ID_W-1:0] start;
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] pos;
        grant = '0;
        start = '0;
        sum   = '0;
        pos   = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            elig[b]      = '0;
            onehot[b]    = '0;
            win_vld[b]   = 1'b0;
            win_id[b]    = '0;
            win_we[b]    = 1'b0;
            win_addr[b]  = '0;
            win_wdata[b] = '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                elig[b][i] = req_valid[i] && !req_ready[i]
                             && (bank_of(req_addr[i*ADDR_W +: ADDR_W]) == b);
            end
            start = (RR_MODE != 0) ? rr_ptr[b] : '0;
            for (int unsigned o = 0; o < NUM_REQ; o++) begin
                sum = {1'b0, start} + (ID_W+1)'(o);
                if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
                pos = sum[ID_W-1:0];
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (!win_vld[b] && elig[b][i] && (pos == ID_W'(i))) begin
                        win_vld[b]   = 1'b1;
                        win_id[b]    = ID_W'(i);
                        onehot[b][i] = 1'b1;
                    end
                end
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (onehot[b][i]) begin
                    win_we[b]    = req_we[i];
                    win_addr[b]  = req_addr[i*ADDR_W +: BA_W];
                    win_wdata[b] = req_wdata[i*DATA_W +: DATA_W];
                end
            end
            grant = grant | onehot[b];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            req_ready  <= '0;
            bank_en    <= '0;
            bank_we    <= '0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                rr_ptr[b]   <= '0;
                issue_id[b] <= '0;
            end
        end else begin
            req_ready <= grant;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                bank_en[b]  <= win_vld[b];
                bank_we[b]  <= win_vld[b] && win_we[b];
                issue_id[b] <= win_id[b];
                if (win_vld[b]) begin
                    bank_addr[b*BA_W +: BA_W] <= win_addr[b];
                    if (win_we[b]) bank_wdata[b*DATA_W +: DATA_W] <= win_wdata[b];
                    if (RR_MODE != 0)
                        rr_ptr[b] <= (win_id[b] == ID_W'(NUM_REQ - 1)) ? '0 : win_id[b] + 1'b1;
                end
            end
        end
    end

    // Tag pipeline is fed from the registered issue so its tail lines up with bank_rdata.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                tag_vld[b] <= '0;
                tag_id[b]  <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                tag_vld[b][0] <= bank_en[b] && !bank_we[b];
                tag_id[b][0]  <= issue_id[b];
                for (int unsigned s = 1; s < RD_LAT; s++) begin
                    tag_vld[b][s] <= tag_vld[b][s-1];
                    tag_id[b][s]  <= tag_id[b][s-1];
                end
            end
        end
    end

    always_comb begin
        rsp_vld_nxt  = '0;
        rsp_data_nxt = rsp_rdata;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (tag_vld[b][RD_LAT-1] && (tag_id[b][RD_LAT-1] == ID_W'(i))) begin
                    rsp_vld_nxt[i] = 1'b1;
                    rsp_data_nxt[i*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rsp_vld_nxt;
            rsp_rdata <= rsp_data_nxt;
        end
    end

    assign stall_any = |(req_valid & ~req_ready & ~grant);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            stall_cnt <= '0;
        else if (stall_clr)
            stall_cnt <= '0;
        else if (stall_any && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_bram_bank_arbiter.sv
// Directed bench for bram_bank_arbiter: round-robin DUT with a BRAM model plus a
// fixed-priority twin sharing its request inputs.
module tb_bram_bank_arbiter;

    localparam int NR = 4;
    localparam int NB = 2;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 12;

    logic               wb_clk_i;
    logic               wb_rst_i;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_we;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic               stall_clr;

    logic [NR-1:0]      req_ready, rsp_valid;
    logic [NR*DW-1:0]   rsp_rdata;
    logic [NB-1:0]      bank_en, bank_we;
    logic [NB*BW-1:0]   bank_addr;
    logic [NB*DW-1:0]   bank_wdata, bank_rdata;
    logic [15:0]        stall_cnt;

    logic [NR-1:0]      fp_ready, fp_rsp_valid;
    logic [NR*DW-1:0]   fp_rsp_rdata;
    logic [NB-1:0]      fp_en, fp_we;
    logic [NB*BW-1:0]   fp_addr;
    logic [NB*DW-1:0]   fp_wdata;
    logic [15:0]        fp_stall;

    int n_cmp = 0;
    int n_mis = 0;

    bram_bank_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW),
                        .RD_LAT(2), .RR_MODE(1)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    bram_bank_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW),
                        .RD_LAT(2), .RR_MODE(0)) dut_fp (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(fp_ready), .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata),
        .bank_en(fp_en), .bank_we(fp_we), .bank_addr(fp_addr),
        .bank_wdata(fp_wdata), .bank_rdata('0),
        .stall_cnt(fp_stall), .stall_clr(stall_clr)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // BRAM model, 2-cycle read latency; unwritten words read as A0bb_0aaa.
    logic [31:0] wr_mem [int unsigned];
    logic [31:0] rd_p1 [NB];
    logic [31:0] rd_p2 [NB];

    function automatic logic [31:0] mem_rd(input int unsigned key);
        if (wr_mem.exists(key)) return wr_mem[key];
        return 32'hA000_0000 | ((key / 4096) << 16) | (key % 4096);
    endfunction

    always @(posedge wb_clk_i) begin
        for (int b = 0; b < NB; b++) begin
            int unsigned key;
            key = 32'(b) * 4096 + 32'(bank_addr[b*BW +: BW]);
            if (bank_en[b] && bank_we[b]) wr_mem[key] = bank_wdata[b*DW +: DW];
            if (bank_en[b] && !bank_we[b]) rd_p1[b] <= mem_rd(key);
            rd_p2[b] <= rd_p1[b];
        end
    end
    assign bank_rdata = {rd_p2[1], rd_p2[0]};

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    logic [3:0] exp_rr [5];
    logic [3:0] exp_fp [5];

    initial begin
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_fp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
        wb_rst_i  = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        stall_clr = 1'b0;
        #2 wb_rst_i = 1'b1;
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_bank_en", 64'({bank_en, bank_we}), 64'h0);
        chk("rst_bank_addr", 64'(bank_addr), 64'h0);
        chk("rst_stall", 64'(stall_cnt), 64'h0);
        wb_rst_i = 1'b0;

        // single read, req 1 -> 0x0005 (bank 0)
        set_req(1, 1'b1, 1'b0, 13'h0005, 32'h0);
        tick();
        chk("t1_ready", 64'(req_ready), 64'h2);
        chk("t1_bank_en", 64'(bank_en), 64'h1);
        chk("t1_bank_we", 64'(bank_we), 64'h0);
        chk("t1_bank_addr", 64'(bank_addr), 64'h000005);
        req_valid = '0;
        tick();
        chk("t1_no_regrant", 64'(req_ready), 64'h0);
        tick();
        chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
        tick();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("t1_rsp_data", 64'(rsp_rdata[1*DW +: DW]), 64'hA000_0005);
        tick();
        chk("t1_rsp_pulse", 64'(rsp_valid), 64'h0);
        chk("t1_stall", 64'(stall_cnt), 64'h0);

        // contention on bank 0 from all requesters, pointers freshly reset
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 13'(13'h0100 + i), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t2_rr_grant%0d", k), 64'(req_ready), 64'(exp_rr[k]));
            chk($sformatf("t2_fp_grant%0d", k), 64'(fp_ready), 64'(exp_fp[k]));
            if (k == 3) begin
                chk("t2_rsp0_valid", 64'(rsp_valid), 64'h1);
                chk("t2_rsp0_data", 64'(rsp_rdata[0 +: DW]), 64'hA000_0100);
            end
            if (k == 4) begin
                chk("t2_rsp1_valid", 64'(rsp_valid), 64'h2);
                chk("t2_rsp1_data", 64'(rsp_rdata[1*DW +: DW]), 64'hA000_0101);
            end
        end
        chk("t2_stall", 64'(stall_cnt), 64'd5);
        chk("t2_fp_stall", 64'(fp_stall), 64'd5);
        req_valid = '0;
        tick();
        tick();
        tick();
        chk("t2_last_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t2_last_rsp_data", 64'(rsp_rdata[0 +: DW]), 64'hA000_0100);
        tick();

        // parallel banks
        set_req(0, 1'b1, 1'b0, 13'h0010, 32'h0);
        set_req(2, 1'b1, 1'b0, 13'h1010, 32'h0);
        tick();
        chk("t3_ready", 64'(req_ready), 64'h5);
        chk("t3_bank_en", 64'(bank_en), 64'h3);
        chk("t3_bank_addr", 64'(bank_addr), 64'h010010);
        req_valid = '0;
        tick();
        chk("t3_no_regrant", 64'(req_ready), 64'h0);
        tick();
        tick();
        chk("t3_rsp_valid", 64'(rsp_valid), 64'h5);
        chk("t3_rsp_data0", 64'(rsp_rdata[0 +: DW]), 64'hA000_0010);
        chk("t3_rsp_data2", 64'(rsp_rdata[2*DW +: DW]), 64'hA001_0010);
        tick();

        // write then read of the same word, back-to-back grants
        set_req(1, 1'b1, 1'b1, 13'h0040, 32'hDEAD_BEEF);
        set_req(3, 1'b1, 1'b0, 13'h0040, 32'h0);
        tick();
        chk("t4_wr_ready", 64'(req_ready), 64'h2);
        chk("t4_wr_bank_we", 64'({bank_en, bank_we}), 64'h5);
        chk("t4_wr_wdata", 64'(bank_wdata[0 +: DW]), 64'hDEAD_BEEF);
        chk("t4_stall", 64'(stall_cnt), 64'd6);
        req_valid[1] = 1'b0;
        tick();
        chk("t4_rd_ready", 64'(req_ready), 64'h8);
        chk("t4_rd_bank_we", 64'({bank_en, bank_we}), 64'h4);
        req_valid[3] = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_rsp_valid", 64'(rsp_valid), 64'h8);
        chk("t4_rsp_data", 64'(rsp_rdata[3*DW +: DW]), 64'hDEAD_BEEF);
        tick();

        // reset one cycle after a read grant
        set_req(2, 1'b1, 1'b0, 13'h0005, 32'h0);
        tick();
        chk("t5_ready", 64'(req_ready), 64'h4);
        req_valid = '0;
        tick();
        wb_rst_i = 1'b1;
        #1;
        chk("t5_rst_ready", 64'(req_ready), 64'h0);
        chk("t5_rst_bank", 64'({bank_en, bank_we, bank_addr}), 64'h0);
        chk("t5_rst_rsp", 64'(rsp_valid), 64'h0);
        chk("t5_rst_stall", 64'(stall_cnt), 64'h0);
        tick();
        wb_rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t5_no_rsp%0d", k), 64'(rsp_valid), 64'h0);
        end
        set_req(0, 1'b1, 1'b0, 13'h1010, 32'h0);
        tick();
        chk("t5_post_ready", 64'(req_ready), 64'h1);
        chk("t5_post_bank_en", 64'(bank_en), 64'h2);
        req_valid = '0;
        tick();
        tick();
        tick();
        chk("t5_post_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t5_post_rsp_data", 64'(rsp_rdata[0 +: DW]), 64'hA001_0010);
        tick();

        // stall counter saturation and clear
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 13'(13'h1000 + i), 32'h0);
        repeat (65533) @(posedge wb_clk_i);
        tick();
        chk("t6_stall_fffe", 64'(stall_cnt), 64'hFFFE);
        tick();
        chk("t6_stall_ffff", 64'(stall_cnt), 64'hFFFF);
        repeat (4) tick();
        chk("t6_stall_sat", 64'(stall_cnt), 64'hFFFF);
        stall_clr = 1'b1;
        tick();
        chk("t6_stall_clr", 64'(stall_cnt), 64'h0);
        stall_clr = 1'b0;
        tick();
        chk("t6_stall_restart", 64'(stall_cnt), 64'h1);
        req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
